audio_sample_fifo: RTL and testbench

Sample buffer directly upstream of the 96 kHz async audio output block. Accepts stereo 16-bit sample pairs from a producer (CPU/DMA/synth) at arbitrary burst rate through a valid/ready handshake. Releases one pair per sample period (clk12 / DIV) on audio_left_sample/audio_right_sample. Holds those outputs stable for the whole period, so the output block's per-cycle latch always captures a coherent pair. Also reports fill level, a low-water flag and underrun statistics.

---
 rtl/audio_sample_fifo.sv | 123 ++++++++++++
 tb/tb_audio_sample_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO that releases one {left,right} pair per DIV clk12 cycles to the audio output block.
// Optional build macro AUDIO_FIFO_HOLD_ON_UNDERRUN_EN: hold the last pair on underrun instead of emitting silence.
module audio_sample_fifo #(
   parameter int DEPTH_LOG2 = 6,
   parameter int DIV        = 125,
   parameter int LOW_WATER  = 16
) (
   input  logic                  clk12,
   input  logic                  reset12,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [15:0]           wr_left,
   input  logic [15:0]           wr_right,
   input  logic                  flush,
   input  logic                  clr_underrun,
   output logic [15:0]           audio_left_sample,
   output logic [15:0]           audio_right_sample,
   output logic                  sample_tick,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  low_water,
   output logic [15:0]           underrun_count
);

   localparam int                DEPTH    = 1 << DEPTH_LOG2;
   localparam int                CW       = $clog2(DIV);
   localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LOW_LVL  = (DEPTH_LOG2 + 1)'(LOW_WATER);
   localparam logic [CW-1:0]     DIV_LAST = CW'(DIV - 1);

   logic [31:0]             mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     level_q, level_d;
   logic [CW-1:0]           div_cnt_q, div_cnt_d;
   logic [15:0]             left_q, left_d, right_q, right_d;
   logic [15:0]             urun_q, urun_d;
   logic                    tick_q, tick_d, low_q, low_d, ready_q, ready_d;
   logic                    tick, push, pop, underrun;

   always_comb begin
      tick     = (div_cnt_q == DIV_LAST);
      push     = wr_valid && ready_q && !flush;
      pop      = tick && (level_q != '0) && !flush;
      underrun = tick && (level_q == '0);

      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      left_d    = left_q;
      right_d   = right_q;
      tick_d    = tick;
      urun_d    = urun_q;

      if (flush) begin
         // div_cnt keeps running so the output sample phase is not disturbed.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         left_d   = '0;
         right_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            left_d   = mem_q[rd_ptr_q][31:16];
            right_d  = mem_q[rd_ptr_q][15:0];
         end
`ifndef AUDIO_FIFO_HOLD_ON_UNDERRUN_EN
         if (underrun) begin
            left_d  = '0;
            right_d = '0;
         end
`endif
         level_d = level_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
      end

      if (clr_underrun) urun_d = '0;
      else if (underrun && (urun_q != 16'hFFFF)) urun_d = urun_q + 16'd1;

      // Ready is registered from next-state level, so a pop never opens a full FIFO in the same cycle.
      low_d   = (level_d < LOW_LVL);
      ready_d = (level_d != FULL_LVL);
   end

   always_ff @(posedge clk12 or posedge reset12) begin
      if (reset12) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         div_cnt_q <= '0;
         left_q    <= '0;
         right_q   <= '0;
         tick_q    <= 1'b0;
         urun_q    <= '0;
         low_q     <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         div_cnt_q <= div_cnt_d;
         left_q    <= left_d;
         right_q   <= right_d;
         tick_q    <= tick_d;
         urun_q    <= urun_d;
         low_q     <= low_d;
         ready_q   <= ready_d;
      end
   end

   always_ff @(posedge clk12) begin
      if (push) mem_q[wr_ptr_q] <= {wr_left, wr_right};
   end

   assign wr_ready           = ready_q;
   assign audio_left_sample  = left_q;
   assign audio_right_sample = right_q;
   assign sample_tick        = tick_q;
   assign level              = level_q;
   assign low_water          = low_q;
   assign underrun_count     = urun_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: ordering, underrun, empty push on tick, flush, full, async reset.
module tb_audio_sample_fifo;

   logic        clk12 = 1'b0;
   logic        reset12 = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [15:0] wr_left = '0, wr_right = '0;
   logic        flush = 1'b0, clr_underrun = 1'b0;
   logic [15:0] audio_left_sample, audio_right_sample;
   logic        sample_tick;
   logic [6:0]  level;
   logic        low_water;
   logic [15:0] underrun_count;

   int n_cmp = 0;
   int n_fail = 0;
   int ecnt;

`ifdef AUDIO_FIFO_HOLD_ON_UNDERRUN_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   localparam logic [57:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 7'd0, 16'd0, 16'd0, 16'd0};

   audio_sample_fifo #(.DEPTH_LOG2(6), .DIV(125), .LOW_WATER(16)) dut (
      .clk12(clk12), .reset12(reset12), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_left(wr_left), .wr_right(wr_right), .flush(flush), .clr_underrun(clr_underrun),
      .audio_left_sample(audio_left_sample), .audio_right_sample(audio_right_sample),
      .sample_tick(sample_tick), .level(level), .low_water(low_water),
      .underrun_count(underrun_count)
   );

   always #5 clk12 = ~clk12;

   // Edges since reset release: after edge k (sampled #1 later) ecnt == k.
   always @(posedge clk12 or posedge reset12) begin
      if (reset12) ecnt <= 0;
      else         ecnt <= ecnt + 1;
   end

   task automatic advance_to(input int n);
      while (ecnt < n) begin
         @(posedge clk12);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] l, input logic [15:0] r);
      int guard = 0;
      wr_valid = 1'b1;
      wr_left  = l;
      wr_right = r;
      while (!wr_ready && guard < 200) begin
         @(posedge clk12);
         #1;
         guard++;
      end
      n_cmp++;
      if (!wr_ready) begin
         n_fail++;
         $display("FAIL push_timeout: wr_ready=%b required 1", wr_ready);
      end
      @(posedge clk12);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset12 = 1'b1;
      repeat (3) @(posedge clk12);
      #1;
      n_cmp++;
      if ({wr_ready, sample_tick, low_water, level, underrun_count, audio_left_sample, audio_right_sample} !== RESET_VEC) begin
         n_fail++;
         $display("FAIL reset_values: got rdy=%b tick=%b low=%b lvl=%0d urun=%h L=%h R=%h",
                  wr_ready, sample_tick, low_water, level, underrun_count, audio_left_sample, audio_right_sample);
      end
      @(negedge clk12);
      reset12 = 1'b0;
      @(posedge clk12);
      #1;
      n_cmp++;
      if ({wr_ready, low_water, level} !== {1'b1, 1'b1, 7'd0}) begin
         n_fail++;
         $display("FAIL ready_after_release: rdy=%b low=%b lvl=%0d required 1/1/0", wr_ready, low_water, level);
      end
   endtask

   task automatic test_order();
      push(16'h1111, 16'hAAAA);
      push(16'h2222, 16'hBBBB);
      push(16'h3333, 16'hCCCC);
      n_cmp++;
      if (level !== 7'd3) begin
         n_fail++;
         $display("FAIL level_after_3: got %0d required 3", level);
      end
      advance_to(124);
      n_cmp++;
      if ({sample_tick, audio_left_sample, audio_right_sample} !== {1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL pre_tick_124: tick=%b L=%h R=%h required 0/0000/0000", sample_tick, audio_left_sample, audio_right_sample);
      end
      advance_to(125);
      n_cmp++;
      if ({sample_tick, level, audio_left_sample, audio_right_sample} !== {1'b1, 7'd2, 32'h1111AAAA}) begin
         n_fail++;
         $display("FAIL tick_125: tick=%b lvl=%0d L=%h R=%h required 1/2/1111/AAAA", sample_tick, level, audio_left_sample, audio_right_sample);
      end
      advance_to(126);
      n_cmp++;
      if ({sample_tick, audio_left_sample, audio_right_sample} !== {1'b0, 32'h1111AAAA}) begin
         n_fail++;
         $display("FAIL hold_126: tick=%b L=%h R=%h required 0/1111/AAAA", sample_tick, audio_left_sample, audio_right_sample);
      end
      advance_to(250);
      n_cmp++;
      if ({sample_tick, audio_left_sample, audio_right_sample} !== {1'b1, 32'h2222BBBB}) begin
         n_fail++;
         $display("FAIL tick_250: tick=%b L=%h R=%h required 1/2222/BBBB", sample_tick, audio_left_sample, audio_right_sample);
      end
      advance_to(375);
      n_cmp++;
      if ({sample_tick, level, audio_left_sample, audio_right_sample} !== {1'b1, 7'd0, 32'h3333CCCC}) begin
         n_fail++;
         $display("FAIL tick_375: tick=%b lvl=%0d L=%h R=%h required 1/0/3333/CCCC", sample_tick, level, audio_left_sample, audio_right_sample);
      end
   endtask

   task automatic test_underrun();
      logic [31:0] exp_out;
      exp_out = HOLD ? 32'h3333CCCC : 32'h0;
      advance_to(500);
      n_cmp++;
      if ({sample_tick, underrun_count, audio_left_sample, audio_right_sample} !== {1'b1, 16'd1, exp_out}) begin
         n_fail++;
         $display("FAIL underrun_first: tick=%b cnt=%0d L=%h R=%h required 1/1/%h", sample_tick, underrun_count, audio_left_sample, audio_right_sample, exp_out);
      end
      advance_to(1000);
      n_cmp++;
      if ({sample_tick, underrun_count, audio_left_sample, audio_right_sample} !== {1'b1, 16'd5, exp_out}) begin
         n_fail++;
         $display("FAIL underrun_five: tick=%b cnt=%0d L=%h R=%h required 1/5/%h", sample_tick, underrun_count, audio_left_sample, audio_right_sample, exp_out);
      end
      clr_underrun = 1'b1;
      @(posedge clk12);
      #1;
      clr_underrun = 1'b0;
      n_cmp++;
      if (underrun_count !== 16'd0) begin
         n_fail++;
         $display("FAIL clr_underrun: got %0d required 0", underrun_count);
      end
   endtask

   task automatic test_push_on_empty_tick();
      logic [31:0] exp_out;
      exp_out = HOLD ? 32'h3333CCCC : 32'h0;
      advance_to(1124);
      wr_valid = 1'b1;
      wr_left  = 16'h5555;
      wr_right = 16'hDDDD;
      @(posedge clk12);
      #1;
      wr_valid = 1'b0;
      n_cmp++;
      if ({sample_tick, underrun_count, level, audio_left_sample, audio_right_sample} !== {1'b1, 16'd1, 7'd1, exp_out}) begin
         n_fail++;
         $display("FAIL empty_push_tick: tick=%b cnt=%0d lvl=%0d L=%h R=%h required 1/1/1/%h", sample_tick, underrun_count, level, audio_left_sample, audio_right_sample, exp_out);
      end
      advance_to(1250);
      n_cmp++;
      if ({sample_tick, underrun_count, level, audio_left_sample, audio_right_sample} !== {1'b1, 16'd1, 7'd0, 32'h5555DDDD}) begin
         n_fail++;
         $display("FAIL empty_push_emit: tick=%b cnt=%0d lvl=%0d L=%h R=%h required 1/1/0/5555/DDDD", sample_tick, underrun_count, level, audio_left_sample, audio_right_sample);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 40; i++) begin
         wr_valid = 1'b1;
         wr_left  = 16'(16'h3000 + i);
         wr_right = 16'(16'h4000 + i);
         @(posedge clk12);
         #1;
      end
      n_cmp++;
      if ({level, low_water} !== {7'd40, 1'b0}) begin
         n_fail++;
         $display("FAIL fill_40: lvl=%0d low=%b required 40/0", level, low_water);
      end
      flush    = 1'b1;
      wr_left  = 16'hBEEF;
      wr_right = 16'hCAFE;
      @(posedge clk12);
      #1;
      flush    = 1'b0;
      wr_valid = 1'b0;
      n_cmp++;
      if ({level, low_water, wr_ready, audio_left_sample, audio_right_sample} !== {7'd0, 1'b1, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL flush: lvl=%0d low=%b rdy=%b L=%h R=%h required 0/1/1/0000/0000", level, low_water, wr_ready, audio_left_sample, audio_right_sample);
      end
      advance_to(1374);
      n_cmp++;
      if (sample_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_phase_pre: tick=%b required 0", sample_tick);
      end
      advance_to(1375);
      n_cmp++;
      if ({sample_tick, underrun_count, level, audio_left_sample, audio_right_sample} !== {1'b1, 16'd2, 7'd0, 32'h0}) begin
         n_fail++;
         $display("FAIL flush_phase_tick: tick=%b cnt=%0d lvl=%0d L=%h R=%h required 1/2/0/0000/0000", sample_tick, underrun_count, level, audio_left_sample, audio_right_sample);
      end
   endtask

   task automatic test_full();
      int acc = 0;
      while (ecnt < 1500) begin
         wr_valid = 1'b1;
         wr_left  = 16'(16'h1000 + acc);
         wr_right = 16'(16'h2000 + acc);
         if (wr_ready) acc++;
         @(posedge clk12);
         #1;
         if (ecnt == 1390) begin
            n_cmp++;
            if ({level, low_water} !== {7'd15, 1'b1}) begin
               n_fail++;
               $display("FAIL low_water_15: lvl=%0d low=%b required 15/1", level, low_water);
            end
         end
         if (ecnt == 1391) begin
            n_cmp++;
            if ({level, low_water} !== {7'd16, 1'b0}) begin
               n_fail++;
               $display("FAIL low_water_16: lvl=%0d low=%b required 16/0", level, low_water);
            end
         end
         if (ecnt == 1440) begin
            n_cmp++;
            if ({level, wr_ready} !== {7'd64, 1'b0}) begin
               n_fail++;
               $display("FAIL full_64: lvl=%0d rdy=%b required 64/0", level, wr_ready);
            end
         end
      end
      wr_valid = 1'b0;
      n_cmp++;
      if (acc !== 64) begin
         n_fail++;
         $display("FAIL accept_count: got %0d required 64", acc);
      end
      n_cmp++;
      if ({sample_tick, level, wr_ready, audio_left_sample, audio_right_sample} !== {1'b1, 7'd63, 1'b1, 32'h10002000}) begin
         n_fail++;
         $display("FAIL full_pop: tick=%b lvl=%0d rdy=%b L=%h R=%h required 1/63/1/1000/2000", sample_tick, level, wr_ready, audio_left_sample, audio_right_sample);
      end
   endtask

   task automatic test_async_reset();
      flush = 1'b1;
      @(posedge clk12);
      #1;
      flush = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1'b1;
         wr_left  = 16'(16'h6000 + i);
         wr_right = 16'(16'h6100 + i);
         @(posedge clk12);
         #1;
      end
      wr_valid = 1'b0;
      n_cmp++;
      if (level !== 7'd20) begin
         n_fail++;
         $display("FAIL level_20: got %0d required 20", level);
      end
      advance_to(1560);
      #2;
      reset12 = 1'b1;
      #1;
      n_cmp++;
      if ({wr_ready, sample_tick, low_water, level, underrun_count, audio_left_sample, audio_right_sample} !== RESET_VEC) begin
         n_fail++;
         $display("FAIL async_reset: rdy=%b tick=%b low=%b lvl=%0d urun=%h L=%h R=%h",
                  wr_ready, sample_tick, low_water, level, underrun_count, audio_left_sample, audio_right_sample);
      end
      repeat (2) @(posedge clk12);
      @(negedge clk12);
      reset12 = 1'b0;
      push(16'h7777, 16'h8888);
      advance_to(124);
      n_cmp++;
      if ({sample_tick, level, audio_left_sample, audio_right_sample} !== {1'b0, 7'd1, 32'h0}) begin
         n_fail++;
         $display("FAIL rst_pre_tick: tick=%b lvl=%0d L=%h R=%h required 0/1/0000/0000", sample_tick, level, audio_left_sample, audio_right_sample);
      end
      advance_to(125);
      n_cmp++;
      if ({sample_tick, level, audio_left_sample, audio_right_sample} !== {1'b1, 7'd0, 32'h77778888}) begin
         n_fail++;
         $display("FAIL rst_first_tick: tick=%b lvl=%0d L=%h R=%h required 1/0/7777/8888", sample_tick, level, audio_left_sample, audio_right_sample);
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_underrun();
      test_push_on_empty_tick();
      test_flush();
      test_full();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
